// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 1-entry skid buffer.
// The upstream ready is registered, so a stall moves back one stage per cycle.
// Two flush classes (predicted-taken, EX mispredict) empty the stage; saturating
// counters track stall cycles and each flush class for performance debug.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   in_valid_i/in_data_i    upstream payload; in_ready_o is the registered accept
//   out_valid_o/out_data_o  downstream payload; out_ready_i=0 stalls the stage
//   flush_i, flush_ex_i     predicted-taken / EX-mispredict flush
//   stall_cnt_o             cycles with out_valid_o=1 and out_ready_i=0
//   flush_cnt_o             cycles with flush_i=1 and flush_ex_i=0
//   flush_ex_cnt_o          cycles with flush_ex_i=1
module pipe_skid_stage #(
    parameter int unsigned        DATA_W    = 64,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    input  logic              flush_ex_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  flush_ex_cnt_o
);

    // Encoding is {skid_valid, out_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   flush_ex_cnt_q, flush_ex_cnt_d;

    logic               out_valid;
    logic               accept;
    logic               drain;
    logic               flush_any;

    assign out_valid = state_q[0];
    assign accept    = in_valid_i & in_ready_q;
    assign drain     = out_valid & out_ready_i;
    assign flush_any = flush_i | flush_ex_i;

    // Next-state, payload movement and counter update.
    always_comb begin
        state_d        = state_q;
        main_d         = main_q;
        skid_d         = skid_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        flush_ex_cnt_d = flush_ex_cnt_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_data_i;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = in_data_i;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data_i;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready_q is low here, so only a drain can move data.
                if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins over everything; a same-cycle accept is dropped.
        if (flush_any) begin
            state_d = EMPTY;
        end

        in_ready_d = (state_d != FULL);

        if (out_valid && !out_ready_i && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_i && !flush_ex_i && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (flush_ex_i && flush_ex_cnt_q != CNT_MAX) begin
            flush_ex_cnt_d = flush_ex_cnt_q + CNT_W'(1);
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= EMPTY;
            main_q         <= FLUSH_VAL;
            skid_q         <= FLUSH_VAL;
            in_ready_q     <= 1'b1;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            flush_ex_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            main_q         <= main_d;
            skid_q         <= skid_d;
            in_ready_q     <= in_ready_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            flush_ex_cnt_q <= flush_ex_cnt_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign out_valid_o    = out_valid;
    // Bubbles always show the NOP encoding, never a stale payload.
    assign out_data_o     = out_valid ? main_q : FLUSH_VAL;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign flush_ex_cnt_o = flush_ex_cnt_q;

endmodule
